// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU/shifter, overflow detection
// and the EX/MEM pipeline register with hold and flush control.
module ex_mem_stage #(
   parameter int W        = 32,
   parameter bit OVF_KILL = 1'b1
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Hold,
   input  logic          Flush,
   input  logic [W-1:0]  Ex_busA,
   input  logic [W-1:0]  Ex_busB,
   input  logic [W-1:0]  Ex_imm16Ext,
   input  logic [4:0]    Ex_ra,
   input  logic [4:0]    Ex_rb,
   input  logic [4:0]    Ex_rw,
   input  logic [4:0]    Ex_rd,
   input  logic [4:0]    Ex_shf,
   input  logic          Ex_RegWr,
   input  logic          Ex_RegDst,
   input  logic          Ex_ALUsrc,
   input  logic          Ex_MemtoReg,
   input  logic          Ex_ALUshf,
   input  logic [1:0]    Ex_MemWr,
   input  logic [1:0]    Ex_MemRead,
   input  logic [3:0]    Ex_ALUctr,
   input  logic [29:0]   Ex_PC,
   input  logic          Wr_RegWr,
   input  logic [4:0]    Wr_rw,
   input  logic [W-1:0]  Wr_busW,
   output logic [W-1:0]  Mem_ALUout,
   output logic [W-1:0]  Mem_busB,
   output logic [4:0]    Mem_rw,
   output logic          Mem_RegWr,
   output logic          Mem_MemtoReg,
   output logic          Mem_Ovf,
   output logic [1:0]    Mem_MemWr,
   output logic [1:0]    Mem_MemRead,
   output logic [29:0]   Mem_PC
);

   logic [W-1:0] fwd_a_s;
   logic [W-1:0] fwd_b_s;
   logic [W-1:0] op_b_s;
   logic [4:0]   shamt_s;
   logic [W-1:0] sum_s;
   logic [W-1:0] diff_s;
   logic [W-1:0] alu_s;
   logic         ovf_s;
   logic [4:0]   dst_s;
   logic         reg_wr_s;

   // Operand forwarding; a load sitting in MEM is never a forwarding source.
   always_comb begin
      fwd_a_s = Ex_busA;
      fwd_b_s = Ex_busB;
      if (Ex_ra != 5'd0 && Mem_RegWr && !Mem_MemtoReg && Mem_rw == Ex_ra) begin
         fwd_a_s = Mem_ALUout;
      end else if (Ex_ra != 5'd0 && Wr_RegWr && Wr_rw == Ex_ra) begin
         fwd_a_s = Wr_busW;
      end else begin
         fwd_a_s = Ex_busA;
      end
      if (Ex_rb != 5'd0 && Mem_RegWr && !Mem_MemtoReg && Mem_rw == Ex_rb) begin
         fwd_b_s = Mem_ALUout;
      end else if (Ex_rb != 5'd0 && Wr_RegWr && Wr_rw == Ex_rb) begin
         fwd_b_s = Wr_busW;
      end else begin
         fwd_b_s = Ex_busB;
      end
   end

   assign op_b_s  = Ex_ALUsrc ? Ex_imm16Ext : fwd_b_s;
   assign shamt_s = Ex_ALUshf ? Ex_shf : fwd_a_s[4:0];
   assign sum_s   = fwd_a_s + op_b_s;
   assign diff_s  = fwd_a_s - op_b_s;
   assign dst_s   = Ex_RegDst ? Ex_rd : Ex_rw;

   // ALU result and signed overflow (ADD/SUB only).
   always_comb begin
      alu_s = {W{1'b0}};
      ovf_s = 1'b0;
      case (Ex_ALUctr)
         4'h0: alu_s = sum_s;
         4'h1: begin
            alu_s = sum_s;
            ovf_s = (fwd_a_s[W-1] == op_b_s[W-1]) && (sum_s[W-1] != fwd_a_s[W-1]);
         end
         4'h2: alu_s = diff_s;
         4'h3: begin
            alu_s = diff_s;
            ovf_s = (fwd_a_s[W-1] != op_b_s[W-1]) && (diff_s[W-1] != fwd_a_s[W-1]);
         end
         4'h4: alu_s = fwd_a_s & op_b_s;
         4'h5: alu_s = fwd_a_s | op_b_s;
         4'h6: alu_s = fwd_a_s ^ op_b_s;
         4'h7: alu_s = ~(fwd_a_s | op_b_s);
         4'h8: alu_s = {{(W-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
         4'h9: alu_s = {{(W-1){1'b0}}, (fwd_a_s < op_b_s)};
         4'hA: alu_s = op_b_s << shamt_s;
         4'hB: alu_s = op_b_s >> shamt_s;
         4'hC: alu_s = $unsigned($signed(op_b_s) >>> shamt_s);
         4'hD: alu_s = {op_b_s[15:0], 16'd0};
         default: alu_s = op_b_s;
      endcase
   end

   assign reg_wr_s = Ex_RegWr & ~(OVF_KILL & ovf_s);

   // EX/MEM register: Hold outranks Flush; a flushed slot is an all-zero bubble.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Mem_ALUout   <= {W{1'b0}};
         Mem_busB     <= {W{1'b0}};
         Mem_rw       <= 5'd0;
         Mem_RegWr    <= 1'b0;
         Mem_MemtoReg <= 1'b0;
         Mem_Ovf      <= 1'b0;
         Mem_MemWr    <= 2'd0;
         Mem_MemRead  <= 2'd0;
         Mem_PC       <= 30'd0;
      end else if (!Hold) begin
         if (Flush) begin
            Mem_ALUout   <= {W{1'b0}};
            Mem_busB     <= {W{1'b0}};
            Mem_rw       <= 5'd0;
            Mem_RegWr    <= 1'b0;
            Mem_MemtoReg <= 1'b0;
            Mem_Ovf      <= 1'b0;
            Mem_MemWr    <= 2'd0;
            Mem_MemRead  <= 2'd0;
            Mem_PC       <= 30'd0;
         end else begin
            Mem_ALUout   <= alu_s;
            Mem_busB     <= fwd_b_s;
            Mem_rw       <= dst_s;
            Mem_RegWr    <= reg_wr_s;
            Mem_MemtoReg <= Ex_MemtoReg;
            Mem_Ovf      <= ovf_s;
            Mem_MemWr    <= Ex_MemWr;
            Mem_MemRead  <= Ex_MemRead;
            Mem_PC       <= Ex_PC;
         end
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

   logic        Clk = 1'b0;
   logic        Rst_n, Hold, Flush;
   logic [31:0] Ex_busA, Ex_busB, Ex_imm16Ext;
   logic [4:0]  Ex_ra, Ex_rb, Ex_rw, Ex_rd, Ex_shf;
   logic        Ex_RegWr, Ex_RegDst, Ex_ALUsrc, Ex_MemtoReg, Ex_ALUshf;
   logic [1:0]  Ex_MemWr, Ex_MemRead;
   logic [3:0]  Ex_ALUctr;
   logic [29:0] Ex_PC;
   logic        Wr_RegWr;
   logic [4:0]  Wr_rw;
   logic [31:0] Wr_busW;
   logic [31:0] Mem_ALUout, Mem_busB;
   logic [4:0]  Mem_rw;
   logic        Mem_RegWr, Mem_MemtoReg, Mem_Ovf;
   logic [1:0]  Mem_MemWr, Mem_MemRead;
   logic [29:0] Mem_PC;

   int tests = 0;
   int fails = 0;

   ex_mem_stage #(.W(32), .OVF_KILL(1'b1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Hold(Hold), .Flush(Flush),
      .Ex_busA(Ex_busA), .Ex_busB(Ex_busB), .Ex_imm16Ext(Ex_imm16Ext),
      .Ex_ra(Ex_ra), .Ex_rb(Ex_rb), .Ex_rw(Ex_rw), .Ex_rd(Ex_rd), .Ex_shf(Ex_shf),
      .Ex_RegWr(Ex_RegWr), .Ex_RegDst(Ex_RegDst), .Ex_ALUsrc(Ex_ALUsrc),
      .Ex_MemtoReg(Ex_MemtoReg), .Ex_ALUshf(Ex_ALUshf),
      .Ex_MemWr(Ex_MemWr), .Ex_MemRead(Ex_MemRead), .Ex_ALUctr(Ex_ALUctr), .Ex_PC(Ex_PC),
      .Wr_RegWr(Wr_RegWr), .Wr_rw(Wr_rw), .Wr_busW(Wr_busW),
      .Mem_ALUout(Mem_ALUout), .Mem_busB(Mem_busB), .Mem_rw(Mem_rw),
      .Mem_RegWr(Mem_RegWr), .Mem_MemtoReg(Mem_MemtoReg), .Mem_Ovf(Mem_Ovf),
      .Mem_MemWr(Mem_MemWr), .Mem_MemRead(Mem_MemRead), .Mem_PC(Mem_PC)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_aluout"}, Mem_ALUout, 32'h0);
      check({tag, "_busb"},   Mem_busB, 32'h0);
      check({tag, "_rw"},     {27'd0, Mem_rw}, 32'h0);
      check({tag, "_ctl"},    {27'd0, Mem_RegWr, Mem_MemtoReg, Mem_Ovf, 2'b00}, 32'h0);
      check({tag, "_mem"},    {28'd0, Mem_MemWr, Mem_MemRead}, 32'h0);
      check({tag, "_pc"},     {2'b00, Mem_PC}, 32'h0);
   endtask

   task automatic clr;
      Ex_busA = 32'h0; Ex_busB = 32'h0; Ex_imm16Ext = 32'h0;
      Ex_ra = 5'd1; Ex_rb = 5'd2; Ex_rw = 5'd3; Ex_rd = 5'd4; Ex_shf = 5'd0;
      Ex_RegWr = 1'b0; Ex_RegDst = 1'b0; Ex_ALUsrc = 1'b0; Ex_MemtoReg = 1'b0;
      Ex_ALUshf = 1'b0; Ex_MemWr = 2'd0; Ex_MemRead = 2'd0; Ex_ALUctr = 4'h0;
      Ex_PC = 30'd0; Wr_RegWr = 1'b0; Wr_rw = 5'd0; Wr_busW = 32'h0;
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst_n = 1'b0; Hold = 1'b0; Flush = 1'b0;
      clr();
      #12;
      check_all_zero("reset");
      Rst_n = 1'b1;

      // ADDU wraps without overflow
      clr(); Ex_ALUctr = 4'h0; Ex_busA = 32'hFFFF_FFFF; Ex_busB = 32'h1; Ex_RegWr = 1'b1;
      tick();
      check("addu_out", Mem_ALUout, 32'h0);
      check("addu_ovf", {31'd0, Mem_Ovf}, 32'h0);
      check("addu_regwr", {31'd0, Mem_RegWr}, 32'h1);

      // ADD overflow kills RegWr
      clr(); Ex_ALUctr = 4'h1; Ex_busA = 32'h7FFF_FFFF; Ex_busB = 32'h1; Ex_RegWr = 1'b1;
      tick();
      check("add_ovf", {31'd0, Mem_Ovf}, 32'h1);
      check("add_regwr", {31'd0, Mem_RegWr}, 32'h0);
      check("add_out", Mem_ALUout, 32'h8000_0000);

      clr(); Ex_ALUctr = 4'h8; Ex_busA = 32'hFFFF_FFFF; Ex_busB = 32'h1; Ex_RegWr = 1'b1;
      tick();
      check("slt", Mem_ALUout, 32'h1);
      clr(); Ex_ALUctr = 4'h9; Ex_busA = 32'hFFFF_FFFF; Ex_busB = 32'h1; Ex_RegWr = 1'b1;
      tick();
      check("sltu", Mem_ALUout, 32'h0);

      // SUB overflow: 0x80000000 - 1
      clr(); Ex_ALUctr = 4'h3; Ex_busA = 32'h8000_0000; Ex_busB = 32'h1; Ex_RegWr = 1'b1;
      tick();
      check("sub_out", Mem_ALUout, 32'h7FFF_FFFF);
      check("sub_ovf", {31'd0, Mem_Ovf}, 32'h1);

      // Forward priority: r5=0x11 in MEM, WB writes r5=0x22
      clr(); Ex_busA = 32'h11; Ex_rw = 5'd5; Ex_RegWr = 1'b1;
      tick();
      clr(); Ex_ra = 5'd5; Ex_rb = 5'd0; Ex_busA = 32'h99; Ex_rw = 5'd6; Ex_RegWr = 1'b1;
      Wr_RegWr = 1'b1; Wr_rw = 5'd5; Wr_busW = 32'h22;
      tick();
      check("fwd_mem", Mem_ALUout, 32'h11);

      // Load writing r5 in MEM must not forward
      clr(); Ex_ra = 5'd0; Ex_busA = 32'h33; Ex_rw = 5'd5; Ex_RegWr = 1'b1; Ex_MemtoReg = 1'b1;
      Wr_RegWr = 1'b1; Wr_rw = 5'd5; Wr_busW = 32'h22;
      tick();
      clr(); Ex_ra = 5'd5; Ex_rb = 5'd0; Ex_busA = 32'h99; Ex_rw = 5'd6; Ex_RegWr = 1'b1;
      Wr_RegWr = 1'b1; Wr_rw = 5'd5; Wr_busW = 32'h22;
      tick();
      check("fwd_wb_load", Mem_ALUout, 32'h22);

      // r0 never forwards even with MEM and WB both targeting it
      clr(); Ex_ra = 5'd2; Ex_busA = 32'h44; Ex_rw = 5'd0; Ex_RegWr = 1'b1;
      tick();
      clr(); Ex_ra = 5'd0; Ex_rb = 5'd0; Ex_busA = 32'h55; Ex_rw = 5'd6; Ex_RegWr = 1'b1;
      Wr_RegWr = 1'b1; Wr_rw = 5'd0; Wr_busW = 32'h22;
      tick();
      check("fwd_r0", Mem_ALUout, 32'h55);

      // Shifts
      clr(); Ex_ALUctr = 4'hC; Ex_ra = 5'd8; Ex_rb = 5'd9; Ex_busB = 32'h8000_0000;
      Ex_ALUshf = 1'b1; Ex_shf = 5'd4; Ex_RegWr = 1'b1; Ex_rw = 5'd6;
      tick();
      check("sra_shf", Mem_ALUout, 32'hF800_0000);
      clr(); Ex_ALUctr = 4'hC; Ex_ra = 5'd8; Ex_rb = 5'd9; Ex_busB = 32'h8000_0000;
      Ex_busA = 32'h24; Ex_ALUshf = 1'b0; Ex_shf = 5'd1; Ex_RegWr = 1'b1; Ex_rw = 5'd6;
      Ex_MemWr = 2'b01; Ex_PC = 30'h123;
      tick();
      check("sra_var", Mem_ALUout, 32'hF800_0000);

      // Hold for three cycles with changing inputs
      Hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clr(); Ex_busA = 32'h1000 + i; Ex_busB = 32'h7; Ex_PC = 30'h200 + 30'(i);
         tick();
         check("hold_out", Mem_ALUout, 32'hF800_0000);
         check("hold_pc", {2'b00, Mem_PC}, 32'h123);
         check("hold_regwr", {31'd0, Mem_RegWr}, 32'h1);
      end
      Flush = 1'b1;
      tick();
      check("holdflush_pc", {2'b00, Mem_PC}, 32'h123);
      check("holdflush_memwr", {30'd0, Mem_MemWr}, 32'h1);
      Hold = 1'b0;
      tick();
      check_all_zero("flush");
      Flush = 1'b0;

      // Store: rb=7 forwarded from WB
      clr(); Ex_ALUsrc = 1'b1; Ex_imm16Ext = 32'h10; Ex_busA = 32'h1000; Ex_rb = 5'd7;
      Ex_busB = 32'h5555; Ex_rw = 5'd7; Ex_rd = 5'd12; Ex_MemWr = 2'b11;
      Wr_RegWr = 1'b1; Wr_rw = 5'd7; Wr_busW = 32'hABCD;
      tick();
      check("sw_busb", Mem_busB, 32'hABCD);
      check("sw_addr", Mem_ALUout, 32'h1010);
      check("sw_rw", {27'd0, Mem_rw}, 32'd7);
      check("sw_memwr", {30'd0, Mem_MemWr}, 32'd3);

      // RegDst selects rd; LUI
      clr(); Ex_ALUctr = 4'hD; Ex_ALUsrc = 1'b1; Ex_imm16Ext = 32'h1234;
      Ex_RegDst = 1'b1; Ex_rd = 5'd12; Ex_rw = 5'd7; Ex_RegWr = 1'b1; Ex_PC = 30'h3F;
      tick();
      check("lui", Mem_ALUout, 32'h1234_0000);
      check("regdst_rw", {27'd0, Mem_rw}, 32'd12);
      check("pre_rst_regwr", {31'd0, Mem_RegWr}, 32'h1);

      // Asynchronous reset mid-cycle
      #2;
      Rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      Rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
